// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: two writebacks, two operand reads with busy bits,
// issue-time busy marking, return-value tap and ready.
interface regfile_sb_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  wen0;
  logic [ADDR_WIDTH-1:0] waddr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  wen1;
  logic [ADDR_WIDTH-1:0] waddr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  busy1;
  logic                  busy2;
  logic                  iss_en;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [DATA_WIDTH-1:0] ret_val;
  logic                  ready;

  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr1, raddr2, iss_en, iss_rd,
    input  rdata1, rdata2, busy1, busy2, ret_val, ready
  );

  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr1, raddr2, iss_en, iss_rd,
    output rdata1, rdata2, busy1, busy2, ret_val, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with busy scoreboard, optional same-cycle write
// forwarding and a post-reset sweep that zeroes every register before use.
module regfile_sb #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned RET_REG        = 10
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;
  localparam logic [ADDR_WIDTH-1:0] RetIdx  = ADDR_WIDTH'(RET_REG);
  localparam logic BypassEn = (BYPASS != 0);

  localparam logic StClear = 1'b0;
  localparam logic StRun   = 1'b1;
  localparam logic StReset = (CLEAR_ON_RESET != 0) ? StClear : StRun;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [Depth-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rf_q [Depth];

  logic run;
  logic wr0_vld, wr1_vld, iss_vld;
  logic hit1_0, hit1_1, hit2_0, hit2_1;
  logic [DATA_WIDTH-1:0] rdata1, rdata2;

  assign run     = (state_q == StRun);
  assign wr0_vld = run && bus.wen0 && (bus.waddr0 != '0);
  assign wr1_vld = run && bus.wen1 && (bus.waddr1 != '0);
  assign iss_vld = run && bus.iss_en && (bus.iss_rd != '0);

  // Forwarding hits; only meaningful when bypass is built in.
  assign hit1_0 = BypassEn && wr0_vld && (bus.waddr0 == bus.raddr1);
  assign hit1_1 = BypassEn && wr1_vld && (bus.waddr1 == bus.raddr1);
  assign hit2_0 = BypassEn && wr0_vld && (bus.waddr0 == bus.raddr2);
  assign hit2_1 = BypassEn && wr1_vld && (bus.waddr1 == bus.raddr2);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LastIdx) begin
        state_d = StRun;
      end
    end
  end

  // Issue applies after writeback so a newer producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr0_vld) begin
      busy_d[bus.waddr0] = 1'b0;
    end
    if (wr1_vld) begin
      busy_d[bus.waddr1] = 1'b0;
    end
    if (iss_vld) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StReset;
      clr_idx_q <= ADDR_WIDTH'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Port 1 is assigned last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      rf_q[clr_idx_q] <= '0;
    end else begin
      if (wr0_vld) begin
        rf_q[bus.waddr0] <= bus.wdata0;
      end
      if (wr1_vld) begin
        rf_q[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if (run && (bus.raddr1 != '0)) begin
      if (hit1_1) begin
        rdata1 = bus.wdata1;
      end else if (hit1_0) begin
        rdata1 = bus.wdata0;
      end else begin
        rdata1 = rf_q[bus.raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (run && (bus.raddr2 != '0)) begin
      if (hit2_1) begin
        rdata2 = bus.wdata1;
      end else if (hit2_0) begin
        rdata2 = bus.wdata0;
      end else begin
        rdata2 = rf_q[bus.raddr2];
      end
    end
  end

  assign bus.rdata1  = rdata1;
  assign bus.rdata2  = rdata2;
  assign bus.busy1   = run && busy_q[bus.raddr1] && !(hit1_0 || hit1_1);
  assign bus.busy2   = run && busy_q[bus.raddr2] && !(hit2_0 || hit2_1);
  assign bus.ret_val = run ? rf_q[RetIdx] : '0;
  assign bus.ready   = run;

endmodule
